// File: rtl/gcd_job_sequencer.sv
// Job FIFO, launch/settle-detect sequencer and result port wrapped around a gcd_calculator core.
// Define GCD_SEQ_STATS_EN to add saturating job/timeout counters (stat_jobs, stat_timeouts).
module gcd_job_sequencer #(
  parameter int WIDTH         = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_CYCLES    = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             core_reset,
  output logic [WIDTH-1:0] core_x,
  output logic [WIDTH-1:0] core_y,
  input  logic [WIDTH-1:0] core_gcd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic             out_timeout
`ifdef GCD_SEQ_STATS_EN
  ,
  output logic [31:0]      stat_jobs,
  output logic [15:0]      stat_timeouts
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int STAB_W = ($clog2(STABLE_CYCLES) > 0) ? $clog2(STABLE_CYCLES) : 1;
  localparam int CYC_W  = ($clog2(MAX_CYCLES) > 0) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   fifo_x [FIFO_DEPTH];
  logic [WIDTH-1:0]   fifo_y [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  logic [WIDTH-1:0]   prev_gcd;
  logic [STAB_W-1:0]  stable_cnt;
  logic [CYC_W-1:0]   cycle_cnt;
  logic               gcd_equal;
  logic               stable_hit;
  logic               cycle_limit;

  assign in_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (count != '0);

  // NOTE: the job storage has no reset; only the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x[wr_ptr] <= in_x;
      fifo_y[wr_ptr] <= in_y;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Settle detection: a run of equal nonzero samples means the core has converged.
  assign gcd_equal   = (core_gcd == prev_gcd) && (core_gcd != '0);
  assign stable_hit  = gcd_equal && (stable_cnt == STAB_W'(STABLE_CYCLES - 1));
  assign cycle_limit = (cycle_cnt == CYC_W'(MAX_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      core_reset  <= 1'b1;
      core_x      <= '0;
      core_y      <= '0;
      out_valid   <= 1'b0;
      out_gcd     <= '0;
      out_x       <= '0;
      out_y       <= '0;
      out_timeout <= 1'b0;
      prev_gcd    <= '0;
      stable_cnt  <= '0;
      cycle_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          core_reset <= 1'b1;
          if (pop) begin
            core_x <= fifo_x[rd_ptr];
            core_y <= fifo_y[rd_ptr];
            state  <= LOAD;
          end
        end
        LOAD: begin
          out_x <= core_x;
          out_y <= core_y;
          if (core_x == '0 || core_y == '0) begin
            // Zero operand: the answer is the other operand, and the core stays in reset.
            out_gcd     <= core_x | core_y;
            out_timeout <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            core_reset <= 1'b0;
            prev_gcd   <= '0;
            stable_cnt <= '0;
            cycle_cnt  <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          prev_gcd  <= core_gcd;
          cycle_cnt <= cycle_cnt + 1'b1;
          if (gcd_equal) stable_cnt <= stable_cnt + 1'b1;
          else           stable_cnt <= '0;
          if (stable_hit || cycle_limit) begin
            out_gcd     <= core_gcd;
            out_timeout <= !stable_hit;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            core_reset <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GCD_SEQ_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_jobs     <= '0;
      stat_timeouts <= '0;
    end else if (out_valid && out_ready) begin
      if (stat_jobs != '1) stat_jobs <= stat_jobs + 1'b1;
      if (out_timeout && stat_timeouts != '1) stat_timeouts <= stat_timeouts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Scoreboard bench for gcd_job_sequencer with a subtraction-based core model and a
// modulo-Euclid reference; covers bypass, backpressure, FIFO full, timeout and mid-job reset.
module tb_gcd_job_sequencer;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int STAB  = 4;
  localparam int MAXC  = 64;

  typedef struct {
    logic [W-1:0] gcd;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         timeout;
  } result_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x, in_y;
  logic         core_reset;
  logic [W-1:0] core_x, core_y;
  logic [W-1:0] core_gcd;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_gcd, out_x, out_y;
  logic         out_timeout;
`ifdef GCD_SEQ_STATS_EN
  logic [31:0]  stat_jobs;
  logic [15:0]  stat_timeouts;
`endif

  logic ready_force;
  logic ready_rand;
  logic rand_mode;
  assign out_ready = rand_mode ? ready_rand : ready_force;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int to_count = 0;
  int core_low_cycles = 0;
  int run_cycles = 0;
  result_t exp_q[$];

  gcd_job_sequencer #(
    .WIDTH(W), .FIFO_DEPTH(DEPTH), .STABLE_CYCLES(STAB), .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .core_reset(core_reset), .core_x(core_x), .core_y(core_y), .core_gcd(core_gcd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_gcd(out_gcd), .out_x(out_x), .out_y(out_y), .out_timeout(out_timeout)
`ifdef GCD_SEQ_STATS_EN
    , .stat_jobs(stat_jobs), .stat_timeouts(stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  // Core stand-in: repeated subtraction, publishing 0 until the operands meet.
  logic [W-1:0] ca, cb;
  always @(posedge clk) begin
    if (core_reset) begin
      ca       <= core_x;
      cb       <= core_y;
      core_gcd <= '0;
    end else begin
      if (ca > cb)      ca <= ca - cb;
      else if (cb > ca) cb <= cb - ca;
      core_gcd <= (ca == cb) ? ca : '0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: Euclid with plain arithmetic. The sum of quotients is the subtraction count
  // the core needs; far beyond the cycle limit the job times out with a zero sample.
  function automatic result_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    result_t r;
    longint unsigned a, b, t, q_sum;
    r.x = x; r.y = y; r.timeout = 1'b0;
    if (x == 0 || y == 0) begin
      r.gcd = x | y;
      return r;
    end
    a = x; b = y; q_sum = 0;
    while (b != 0) begin
      q_sum += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    if (q_sum > MAXC) begin
      r.timeout = 1'b1;
      r.gcd     = '0;
    end else begin
      r.gcd = W'(a);
    end
    return r;
  endfunction

  // Monitor: scoreboard pop on each handshake, plus a hold check under backpressure.
  logic         held_valid = 1'b0;
  logic [96:0]  held;
  always @(negedge clk) begin
    if (reset) begin
      held_valid <= 1'b0;
    end else begin
      if (core_reset == 1'b0) core_low_cycles++;
      if (core_reset == 1'b0 && !out_valid) run_cycles++;
      if (out_valid && held_valid)
        check("hold_stable", {out_gcd, out_x, out_y, out_timeout} == held, 1);
      held_valid <= out_valid && !out_ready;
      held       <= {out_gcd, out_x, out_y, out_timeout};
      if (out_valid && out_ready) begin
        hs_count++;
        if (out_timeout) to_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          result_t e;
          e = exp_q.pop_front();
          check("out_gcd", out_gcd, e.gcd);
          check("out_x", out_x, e.x);
          check("out_y", out_y, e.y);
          check("out_timeout", out_timeout, e.timeout);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1 ready_rand = ($urandom_range(0, 2) != 0);
  end

  task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
    int waited = 0;
    in_valid = 1'b1; in_x = x; in_y = y;
    @(negedge clk);
    while (!in_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("push_timeout", 0, 1);
    end else begin
      exp_q.push_back(model(x, y));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 5000) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
    ready_force = 1'b1; rand_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_gcd", out_gcd, 0);
    check("rst_core_x", core_x, 0);
    check("rst_out_timeout", out_timeout, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Single job: core must be released while it runs, then held again once idle.
    core_low_cycles = 0;
    push(40, 20);
    drain();
    check("job1_core_released", core_low_cycles > 0, 1);
    check("idle_core_reset", core_reset, 1);

    push(40, 20);
    push(10, 60);
    drain();

    // Zero-operand bypass never releases the core.
    core_low_cycles = 0;
    push(0, 7);
    push(0, 0);
    drain();
    check("bypass_core_held", core_low_cycles, 0);

    // Backpressure: one in flight plus DEPTH queued, then the FIFO refuses.
    ready_force = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push(W'($urandom_range(1, 31)), W'($urandom_range(1, 31)));
    in_valid = 1'b1; in_x = 99; in_y = 33;
    repeat (5) @(negedge clk);
    check("full_in_ready", in_ready, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    ready_force = 1'b1;
    drain();
    check("drained_in_ready", in_ready, 1);

    // Randomized jobs with random consumer backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] x, y;
      x = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 31));
      y = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 31));
      push(x, y);
    end
    drain();
    rand_mode = 1'b0;

    // Timeout: exactly MAXC cycles with the core released before the result appears.
    run_cycles = 0;
    push(32'hFFFF_FFFF, 1);
    drain();
    check("timeout_run_cycles", run_cycles, MAXC);

    // Reset mid-run with jobs queued: nothing from before the reset may come out.
    push(32'hFFFF_FFFF, 1);
    push(3, 6);
    push(5, 10);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    hs_count = 0;
    to_count = 0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_core_reset", core_reset, 1);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1 reset = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    check("midrst_no_result", hs_count, 0);
    push(9, 6);
    drain();
    check("post_reset_jobs", hs_count, 1);

`ifdef GCD_SEQ_STATS_EN
    check("stat_jobs", stat_jobs, hs_count);
    check("stat_timeouts", stat_timeouts, to_count);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
